// File: rtl/tile_lookup_scheduler.sv
// -----------------------------------------------------------------------------
// tile_lookup_scheduler
//
// Purpose:
//   Shares one tile-map memory read port between N_REQ requesters that each
//   need the tile type under a pixel position. Requests are served round-robin.
//   A grant samples that requester's X/Y, snaps them to the enclosing tile,
//   reads the map at row*GRID_COLS+col and returns the tile type and the
//   tile's top-left corner, tagged with the requester id. One lookup is in
//   flight at a time: grant in cycle T, map read strobe in T+1, response in T+3.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   req                  per-requester level request
//   reqX, reqY           packed 11-bit pixel coordinates, slice i = [11i+10:11i]
//   gnt                  one-hot 1-cycle pulse; X/Y of that requester sampled
//   map_rd_en, map_addr  map read strobe and address (row*GRID_COLS+col)
//   map_rd_data          map data, valid the cycle after map_rd_en
//   rsp_valid            1-cycle response pulse
//   rsp_id, rsp_tileType, rsp_tileTopLeftX, rsp_tileTopLeftY
//                        response fields, held until the next response
//   dbg_state            current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshake: req is a level; a requester is served in the cycle gnt[i] is high,
// and only the X/Y presented in that cycle are used. Keeping req high after a
// grant is a new request. rsp_valid is a single-cycle strobe with no backpressure.
//
// Optional feature (macro TILE_OOB_CHECK_EN): a tile outside the GRID_COLS x
// GRID_ROWS map suppresses the memory read and returns tile type 0.
// -----------------------------------------------------------------------------
module tile_lookup_scheduler #(
    parameter int N_REQ      = 4,
    parameter int TILE_SHIFT = 6,
    parameter int GRID_COLS  = 10,
    parameter int GRID_ROWS  = 8,
    parameter int TYPE_W     = 4,
    parameter int ADDR_W     = 7,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*11-1:0]   reqX,
    input  logic [N_REQ*11-1:0]   reqY,
    output logic [N_REQ-1:0]      gnt,
    output logic                  map_rd_en,
    output logic [ADDR_W-1:0]     map_addr,
    input  logic [TYPE_W-1:0]     map_rd_data,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [TYPE_W-1:0]     rsp_tileType,
    output logic [10:0]           rsp_tileTopLeftX,
    output logic [10:0]           rsp_tileTopLeftY,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   id_q;
    logic [10:0]       tlx_q;
    logic [10:0]       tly_q;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [10:0]       sel_x;
    logic [10:0]       sel_y;
    logic [10:0]       pick_col;
    logic [10:0]       pick_row;
    logic [ADDR_W-1:0] pick_addr;

    // Round-robin search: first asserted req at or after rr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && req[(int'(rr) + i) % N_REQ]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(rr) + i) % N_REQ);
            end
        end
    end

    assign sel_x    = reqX[int'(pick_id)*11 +: 11];
    assign sel_y    = reqY[int'(pick_id)*11 +: 11];
    assign pick_col = sel_x >> TILE_SHIFT;
    assign pick_row = sel_y >> TILE_SHIFT;
    // Address is formed at full width and then truncated to the map port.
    assign pick_addr = ADDR_W'(32'(pick_row) * 32'(GRID_COLS) + 32'(pick_col));

    // Grant is combinational so X/Y are sampled in the same cycle gnt is seen.
    // Gated by resetN so every output reads 0 while reset is asserted.
    assign gnt = (state == S_IDLE && pick_found && resetN)
                 ? (N_REQ'(1) << pick_id) : '0;

    assign dbg_state = state;

`ifdef TILE_OOB_CHECK_EN
    logic pick_oob;
    logic oob_q;
    assign pick_oob = (int'(pick_col) >= GRID_COLS) || (int'(pick_row) >= GRID_ROWS);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= S_IDLE;
            rr               <= '0;
            id_q             <= '0;
            tlx_q            <= '0;
            tly_q            <= '0;
            map_rd_en        <= 1'b0;
            map_addr         <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_tileType     <= '0;
            rsp_tileTopLeftX <= '0;
            rsp_tileTopLeftY <= '0;
`ifdef TILE_OOB_CHECK_EN
            oob_q            <= 1'b0;
`endif
        end else begin
            map_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        id_q     <= pick_id;
                        tlx_q    <= pick_col << TILE_SHIFT;
                        tly_q    <= pick_row << TILE_SHIFT;
                        map_addr <= pick_addr;
`ifdef TILE_OOB_CHECK_EN
                        // Out-of-map tiles skip the memory strobe but still
                        // pass through the ISSUE slot so latency stays T+3.
                        oob_q     <= pick_oob;
                        map_rd_en <= !pick_oob;
`else
                        map_rd_en <= 1'b1;
`endif
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Memory data is valid this cycle; response goes out next.
`ifdef TILE_OOB_CHECK_EN
                    rsp_tileType <= oob_q ? '0 : map_rd_data;
`else
                    rsp_tileType <= map_rd_data;
`endif
                    rsp_id           <= id_q;
                    rsp_tileTopLeftX <= tlx_q;
                    rsp_tileTopLeftY <= tly_q;
                    rsp_valid        <= 1'b1;
                    state            <= S_RESP;
                end
                S_RESP: begin
                    if (int'(id_q) == N_REQ - 1) rr <= '0;
                    else                         rr <= id_q + ID_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_lookup_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for tile_lookup_scheduler: directed scenarios plus randomized traffic.
// A reference model (round-robin by search over requesters, tile math by
// division/multiplication) pushes expected responses into exp_q at grant time;
// a separate monitor pops and compares whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_tile_lookup_scheduler;

    localparam int N  = 4;
    localparam int TS = 6;
    localparam int GC = 10;
    localparam int GR = 8;
    localparam int TW = 4;
    localparam int AW = 7;
    localparam int IW = 2;
    localparam int EW = 60;  // {due[31:0], id[1:0], type[3:0], tlx[10:0], tly[10:0]}

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*11-1:0] reqX = '0;
    logic [N*11-1:0] reqY = '0;
    logic [N-1:0]    gnt;
    logic            map_rd_en;
    logic [AW-1:0]   map_addr;
    logic [TW-1:0]   map_rd_data = '0;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [TW-1:0]   rsp_tileType;
    logic [10:0]     rsp_tileTopLeftX;
    logic [10:0]     rsp_tileTopLeftY;
    logic [1:0]      dbg_state;

    tile_lookup_scheduler dut (
        .clk              (clk),
        .resetN           (resetN),
        .req              (req),
        .reqX             (reqX),
        .reqY             (reqY),
        .gnt              (gnt),
        .map_rd_en        (map_rd_en),
        .map_addr         (map_addr),
        .map_rd_data      (map_rd_data),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_tileType     (rsp_tileType),
        .rsp_tileTopLeftX (rsp_tileTopLeftX),
        .rsp_tileTopLeftY (rsp_tileTopLeftY),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- map memory model ----------------
    logic [TW-1:0] map_mem [0:(1<<AW)-1];
    always @(posedge clk) if (map_rd_en) map_rd_data <= map_mem[map_addr];

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (runs every negedge) ----------------
    int            m_busy = 0;
    int            m_rr = 0;
    int            rd_cycle = -1;
    logic [AW-1:0] rd_addr = '0;

    always @(negedge clk) begin : model
        logic [N-1:0] eg;
        int w, x, y, col, row, addr, typ;
        bit found, oob;
        eg = '0;
        if (!resetN) begin
            check("reset_outputs",
                  {gnt, map_rd_en, rsp_valid, map_addr, rsp_id, rsp_tileType,
                   rsp_tileTopLeftX, rsp_tileTopLeftY}, 64'd0);
            m_busy = 0; m_rr = 0; rd_cycle = -1;
            exp_q.delete();
        end else begin
            if (m_busy > 0) begin
                m_busy--;
            end else if (req != '0) begin
                found = 0; w = 0;
                for (int i = 0; i < N; i++)
                    if (!found && req[(m_rr + i) % N]) begin found = 1; w = (m_rr + i) % N; end
                eg[w] = 1'b1;
                x = int'(reqX[w*11 +: 11]);
                y = int'(reqY[w*11 +: 11]);
                col  = x / 64;
                row  = y / 64;
                addr = (row * GC + col) % (1 << AW);
`ifdef TILE_OOB_CHECK_EN
                oob = (col >= GC) || (row >= GR);
`else
                oob = 0;
`endif
                typ = oob ? 0 : int'(map_mem[addr]);
                exp_q.push_back({32'(cyc + 3), 2'(w), 4'(typ), 11'(col * 64), 11'(row * 64)});
                rd_cycle = oob ? -1 : cyc + 1;
                rd_addr  = AW'(addr);
                m_busy   = 3;
                m_rr     = (w + 1) % N;
            end
            check("gnt", 64'(gnt), 64'(eg));
            check("map_rd_en", 64'(map_rd_en), 64'(cyc == rd_cycle));
            if (cyc == rd_cycle) check("map_addr", 64'(map_addr), 64'(rd_addr));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (resetN) begin
            if (exp_q.size() > 0 && int'(exp_q[0][59:28]) < cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing", 64'(cyc), 64'(e[59:28]));
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e[59:28]));
                    check("rsp_id", 64'(rsp_id), 64'(e[27:26]));
                    check("rsp_type", 64'(rsp_tileType), 64'(e[25:22]));
                    check("rsp_tlx", 64'(rsp_tileTopLeftX), 64'(e[21:11]));
                    check("rsp_tly", 64'(rsp_tileTopLeftY), 64'(e[10:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step(); resetN = 1'b0; req = '0;
        repeat (2) step();
        resetN = 1'b1;
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        reqX[i*11 +: 11] = 11'(x);
        reqY[i*11 +: 11] = 11'(y);
    endtask

    // Single-cycle request from requester i; X/Y scrambled one cycle later.
    task automatic one_lookup(input int i, input int x, input int y);
        step(); req = N'(1) << i; set_xy(i, x, y);
        step(); req = '0; set_xy(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        repeat (4) step();
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int last, waited, id;
        for (int a = 0; a < (1 << AW); a++) map_mem[a] = TW'($urandom);

        do_reset();

        // Worked example: req[1] at (130,70) -> addr 12, top-left (128,64).
        step(); req = 4'b0010; set_xy(1, 130, 70);
        @(negedge clk); check("ex_gnt", 64'(gnt), 64'h2);
        step(); req = '0; set_xy(1, 5, 5);
        @(negedge clk); check("ex_rd_en", 64'(map_rd_en), 64'd1);
        check("ex_addr", 64'(map_addr), 64'd12);
        repeat (2) @(negedge clk);
        check("ex_rsp_valid", 64'(rsp_valid), 64'd1);
        check("ex_tl", {rsp_tileTopLeftX, rsp_tileTopLeftY}, {11'd128, 11'd64});
        check("ex_type", 64'(rsp_tileType), 64'(map_mem[12]));
        repeat (3) step();

        // Tile boundary on requester 2.
        one_lookup(2, 63, 63);
        one_lookup(2, 64, 0);

        // Column 10 is outside the map.
        step(); req = 4'b0001; set_xy(0, 700, 0);
        step(); req = '0;
        @(negedge clk);
`ifdef TILE_OOB_CHECK_EN
        check("oob_rd_en", 64'(map_rd_en), 64'd0);
`else
        check("oob_rd_en", 64'(map_rd_en), 64'd1);
        check("oob_addr", 64'(map_addr), 64'd10);
`endif
        repeat (4) step();

        // Reset during WAIT: lookup aborted, no response afterwards.
        step(); req = 4'b1000; set_xy(3, 300, 200);
        step(); req = '0;
        step(); resetN = 1'b0;
        repeat (2) step();
        resetN = 1'b1;
        repeat (6) step();

        // All requesting after reset: order 0,1,2,3,0 every 4 cycles.
        do_reset();
        for (int i = 0; i < N; i++) set_xy(i, 64 * i + 7, 64 * i + 9);
        req = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            @(negedge clk);
            while (gnt == '0 && waited < 8) begin @(negedge clk); waited++; end
            if (gnt == '0) begin
                check("rr_timeout", 64'(waited), 64'd0);
            end else begin
                id = 0;
                for (int i = 0; i < N; i++) if (gnt[i]) id = i;
                check("rr_order", 64'(id), 64'(k % N));
                if (k > 0) check("rr_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
            end
        end
        step(); req = '0;
        repeat (6) step();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            step();
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0)
                    set_xy(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
                else
                    set_xy(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 600)));
            end
        end
        step(); req = '0;
        repeat (10) step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
